fx2fl_conv_arbiter: RTL and testbench



---
 rtl/fx2fl_conv_arbiter.sv | 83 ++++++++
 tb/tb_fx2fl_conv_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/fx2fl_conv_arbiter.sv
// fx2fl_conv_arbiter: round-robin sharing of one Q16.16-to-float32 converter with a registered valid/ready output stage
module fixedp2floatp (
  input  logic [31:0] fixed,
  output logic [31:0] fp
);
  logic [31:0] mag, sh;
  logic [4:0]  p;
  logic        rnd;
  // normalise magnitude to bit 31, round to nearest even on the 8 dropped bits
  always_comb begin
    mag = fixed[31] ? -fixed : fixed;
    p = '0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i[4:0];
    sh = mag << (5'd31 - p);
    rnd = sh[7] && ((|sh[6:0]) || sh[8]);
    fp = (mag == '0) ? '0 : {fixed[31], 8'(p) + 8'd111, sh[30:8]} + 32'(rnd);
  end
endmodule

module fx2fl_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_fixed,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [31:0]           out_float,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      conv_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state, state_n;
  logic [ID_W-1:0]  ptr, g;
  logic             any, can_accept, acc;
  logic [31:0]      conv;

  fixedp2floatp u_conv (.fixed(req_fixed[32*g +: 32]), .fp(conv));

  // first valid requester at or after the pointer, wrapping around
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!any && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        any = 1'b1;
        g = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
  end

  // grant handshake and output-stage next state
  always_comb begin
    can_accept = (state == EMPTY) || out_ready;
    req_ready = (rst_n && any && can_accept) ? NUM_REQ'(1) << g : '0;
    acc = |(req_valid & req_ready);
    state_n = acc ? FULL : (out_ready ? EMPTY : state);
  end

  // output register, pointer advance on acceptance, consumption counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr <= '0;
      out_float <= '0;
      out_id <= '0;
      conv_count <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        out_float <= conv;
        out_id <= g;
        ptr <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
      end
      if (state == FULL && out_ready) conv_count <= conv_count + 1'b1;
    end
  end

  assign out_valid = (state == FULL);
endmodule

// File: tb/tb_fx2fl_conv_arbiter.sv
// tb_fx2fl_conv_arbiter: directed vector table plus counter-wrap sequence
module tb_fx2fl_conv_arbiter;
  logic         clk = 0, rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_fixed;
  logic         out_valid, out_ready;
  logic [31:0]  out_float;
  logic [1:0]   out_id;
  logic [15:0]  conv_count;
  int checks = 0, errors = 0;

  fx2fl_conv_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_fixed(req_fixed),
    .req_ready(req_ready), .out_valid(out_valid), .out_float(out_float),
    .out_id(out_id), .out_ready(out_ready), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] f0, f1, f2, f3;
    logic        ordy;
    logic [3:0]  rr;
    logic        ov;
    logic [31:0] of;
    logic [1:0]  id;
    logic [15:0] cnt;
  } vec_t;

  localparam logic [31:0] A = 32'h0001_0000, B = 32'h0002_0000, C = 32'h0000_8000, D = 32'h0;
  vec_t v [26];

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  initial begin
    v[0]  = '{1, 4'b0001, 32'hFFFD_8000, 0, 0, 0, 1, 4'b0001, 1, 32'hC020_0000, 0, 0};
    v[1]  = '{1, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 32'hC020_0000, 0, 1};
    v[2]  = '{1, 4'b1111, A, B, C, D, 1, 4'b0010, 1, 32'h4000_0000, 1, 1};
    v[3]  = '{1, 4'b1111, A, B, C, D, 1, 4'b0100, 1, 32'h3F00_0000, 2, 2};
    v[4]  = '{1, 4'b1111, A, B, C, D, 1, 4'b1000, 1, 32'h0000_0000, 3, 3};
    v[5]  = '{1, 4'b1111, A, B, C, D, 1, 4'b0001, 1, 32'h3F80_0000, 0, 4};
    v[6]  = '{1, 4'b1111, A, B, C, D, 1, 4'b0010, 1, 32'h4000_0000, 1, 5};
    for (int i = 7; i < 12; i++)
      v[i] = '{1, 4'b1111, A, B, C, D, 0, 4'b0000, 1, 32'h4000_0000, 1, 5};
    v[12] = '{1, 4'b1111, A, B, C, D, 1, 4'b0100, 1, 32'h3F00_0000, 2, 6};
    v[13] = '{1, 4'b1010, A, B, C, D, 1, 4'b1000, 1, 32'h0000_0000, 3, 7};
    v[14] = '{1, 4'b1010, A, B, C, D, 1, 4'b0010, 1, 32'h4000_0000, 1, 8};
    v[15] = '{1, 4'b1010, A, B, C, D, 1, 4'b1000, 1, 32'h0000_0000, 3, 9};
    v[16] = '{1, 4'b0000, A, B, C, D, 1, 4'b0000, 0, 32'h0000_0000, 3, 10};
    v[17] = '{1, 4'b0000, A, B, C, D, 1, 4'b0000, 0, 32'h0000_0000, 3, 10};
    v[18] = '{1, 4'b0000, A, B, C, D, 1, 4'b0000, 0, 32'h0000_0000, 3, 10};
    v[19] = '{1, 4'b1010, A, B, C, D, 1, 4'b0010, 1, 32'h4000_0000, 1, 10};
    v[20] = '{1, 4'b1111, A, B, C, D, 0, 4'b0000, 1, 32'h4000_0000, 1, 10};
    v[21] = '{0, 4'b1111, A, B, C, D, 0, 4'b0000, 0, 32'h0000_0000, 0, 0};
    v[22] = '{1, 4'b1111, A, B, C, D, 1, 4'b0001, 1, 32'h3F80_0000, 0, 0};
    v[23] = '{1, 4'b0010, 0, 32'h8000_0000, 0, 0, 1, 4'b0010, 1, 32'hC700_0000, 1, 1};
    v[24] = '{1, 4'b0100, 0, 0, 32'h7FFF_FFFF, 0, 1, 4'b0100, 1, 32'h4700_0000, 2, 2};
    v[25] = '{1, 4'b1000, 0, 0, 0, 32'h0000_0001, 1, 4'b1000, 1, 32'h3780_0000, 3, 3};

    rst_n = 0; req_valid = 4'b1111; req_fixed = {D, C, B, A}; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", -1, 32'(req_ready), 0);
    chk("reset_out_valid", -1, 32'(out_valid), 0);
    chk("reset_out_float", -1, out_float, 0);
    chk("reset_out_id", -1, 32'(out_id), 0);
    chk("reset_conv_count", -1, 32'(conv_count), 0);
    rst_n = 1; req_valid = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      rst_n = v[i].rst; req_valid = v[i].rv; out_ready = v[i].ordy;
      req_fixed = {v[i].f3, v[i].f2, v[i].f1, v[i].f0};
      #1;
      chk("req_ready", i, 32'(req_ready), 32'(v[i].rr));
      @(posedge clk); #1;
      chk("out_valid", i, 32'(out_valid), 32'(v[i].ov));
      chk("out_float", i, out_float, v[i].of);
      chk("out_id", i, 32'(out_id), 32'(v[i].id));
      chk("conv_count", i, 32'(conv_count), 32'(v[i].cnt));
    end

    rst_n = 1; req_valid = 4'b0001; req_fixed = {D, C, B, A}; out_ready = 1;
    repeat (65532) @(posedge clk);
    #1;
    chk("count_max", 26, 32'(conv_count), 32'hFFFF);
    @(posedge clk); #1;
    chk("count_wrap", 27, 32'(conv_count), 0);
    chk("wrap_out_valid", 27, 32'(out_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
